round_controller: RTL and testbench
===================================

Name: round_controller

Overview:
- Match sequencer for the two-player light-cycle game; sits between the collision detector and the score display path.
- Runs board clear, play, post-round hold and match-over phases.
- Converts crash flags into single-cycle score-award strobes, and keeps shadow scores so it can declare the match winner.
- Drives the per-player score counters (increment strobes plus clear) and the movement enable of the game logic.

Parameters:
- WIN_SCORE, 10: points needed to win the match; legal range 1..15.
- CLEAR_CYCLES, 19200: cycles spent in CLEAR while the board-wipe engine runs; must be ≥1.
- HOLD_CYCLES, 50000000: post-round freeze in cycles (1 s at 50 MHz); must be ≥1.
- CNT_W, 26: width of the shared phase timer; must hold max(CLEAR_CYCLES, HOLD_CYCLES).

Ports:
- clk, input, 1: system clock.
- reset, input, 1: synchronous, active-high; clears all state, including scores.
- start, input, 1: level; sampled in IDLE and MATCH_OVER to begin a match.
- p1_crash, input, 1: player 1 collided; level, valid only in PLAY.
- p2_crash, input, 1: player 2 collided; level, valid only in PLAY.
- game_run, output, 1: movement enable to the game logic; high only in PLAY.
- board_clear, output, 1: wipe request to the VGA board engine; high throughout CLEAR.
- p1_point, output, 1: one-cycle strobe; player 1 awarded a point.
- p2_point, output, 1: one-cycle strobe; player 2 awarded a point.
- score_clear, output, 1: one-cycle strobe; zero the display score counters.
- p1_score, output, 4: shadow score of player 1, binary.
- p2_score, output, 4: shadow score of player 2, binary.
- match_over, output, 1: high in MATCH_OVER.
- winner, output, 2: 00 none, 01 player 1, 10 player 2; sampled when match_over is high.

Behaviour:
- Reset values: state IDLE; timer 0; every output 0; p1_score and p2_score 0; winner 00.
- IDLE:
  - All strobes low.
  - start=1 → go to CLEAR next cycle, pulse score_clear for 1 cycle, zero both shadow scores.
- CLEAR:
  - board_clear=1; timer counts 0..CLEAR_CYCLES-1.
  - After the last count → PLAY; CLEAR lasts exactly CLEAR_CYCLES cycles.
- PLAY:
  - game_run=1; crash inputs sampled every cycle.
  - Only p1_crash → player 2 scores; only p2_crash → player 1 scores.
  - Both in the same cycle → draw, no point.
  - Any crash → ROUND_END next cycle; game_run drops in that same next cycle.
- ROUND_END (exactly one cycle):
  - Assert the pending point strobe (p1_point or p2_point) and increment the matching shadow score; a draw asserts neither.
  - Shadow score saturates at 15; the strobe is still issued at saturation.
  - Compare the post-increment scores against WIN_SCORE combinationally.
  - Winner reached → MATCH_OVER; otherwise → HOLD.
- HOLD:
  - All outputs idle except the score displays; crash inputs ignored.
  - After HOLD_CYCLES cycles → CLEAR.
- MATCH_OVER:
  - match_over=1; winner held stable.
  - start=1 → same actions as start from IDLE: score_clear strobe, scores zeroed, winner → 00, go to CLEAR.
- Latency: crash asserted at cycle N → game_run low and point strobe at N+1.
- Strobe exclusivity: p1_point, p2_point and score_clear are mutually exclusive and never high for two consecutive cycles.
- start outside IDLE/MATCH_OVER: ignored.
- Crash outside PLAY: ignored.
- Reset in any state, mid-round included: returns to IDLE next edge; no point strobe is issued for a round cut short.
- Timer: zeroed on every state entry; never wraps, because its terminal compare ends the phase.

Optional Feature:
- Macro ROUND_CTRL_WIN_BY_TWO_EN.
- Defined: a match win needs score ≥ WIN_SCORE AND a lead ≥ 2 over the opponent.
  - If both players reach 15 without a two-point lead, the next decisive round wins the match.
- Undefined: first player to reach WIN_SCORE wins.

Decomposition:
- Shared package tron_pkg holds:
  - The state enum: IDLE, CLEAR, PLAY, ROUND_END, HOLD, MATCH_OVER.
  - Winner encodings: WIN_NONE=2'b00, WIN_P1=2'b01, WIN_P2=2'b10.
  - Default timing constants.
- One natural sub-module, phase_timer: loadable down/up counter with a terminal-count flag, reused for CLEAR and HOLD.

Test Plan (WIN_SCORE=3, CLEAR_CYCLES=3, HOLD_CYCLES=4):
- Reset, then start pulse → score_clear high 1 cycle; board_clear high 3 cycles; then game_run=1.
- In PLAY, p2_crash at cycle N → p1_point high only at N+1; p1_score=1; game_run=0 at N+1; HOLD 4 cycles; then CLEAR.
- p1_crash and p2_crash in the same cycle → no point strobe; scores unchanged; HOLD; CLEAR.
- Player 1 wins 3 decisive rounds → match_over=1, winner=01, p1_score=3; later start → scores 0, winner 00, CLEAR.
- reset asserted 2 cycles into PLAY together with p1_crash → IDLE next edge; no strobe; all outputs 0.
- With ROUND_CTRL_WIN_BY_TWO_EN: scores 3:2 → no match over; 4:2 → match_over, winner=01.

Source files
------------

// File: rtl/tron_pkg.sv
// Shared definitions for the light-cycle game: match states, winner codes,
// default timing constants and a saturating score increment.
package tron_pkg;

    // Match sequencer states
    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] CLEAR      = 3'd1;
    localparam logic [2:0] PLAY       = 3'd2;
    localparam logic [2:0] ROUND_END  = 3'd3;
    localparam logic [2:0] HOLD       = 3'd4;
    localparam logic [2:0] MATCH_OVER = 3'd5;

    // Winner encodings
    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;

    // Default timing (50 MHz system clock)
    localparam int unsigned DEF_WIN_SCORE    = 10;
    localparam int unsigned DEF_CLEAR_CYCLES = 19200;
    localparam int unsigned DEF_HOLD_CYCLES  = 50000000;
    localparam int unsigned DEF_CNT_W        = 26;

    // Score counters stick at 15 rather than wrapping
    function automatic logic [3:0] sat_inc(input logic [3:0] s);
        return (s == 4'hF) ? s : s + 4'd1;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Shared phase timer: up-counter cleared on phase entry, with a terminal-count
// flag raised on the last cycle of the phase (count == limit - 1).
module phase_timer #(
    parameter int unsigned CNT_W = 26
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] limit,
    output logic             done
);

    logic [CNT_W-1:0] count;

    // Terminal compare ends the phase, so the counter stops there instead of wrapping
    always_comb begin
        done = (count == limit - 1'b1);
    end

    // Count up while enabled; clear on reset or phase change
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (en && !done) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/round_controller.sv
// Match sequencer for the two-player light-cycle game.
// Optional build macro ROUND_CTRL_WIN_BY_TWO_EN: a match win additionally
// needs a two-point lead (with a sudden-death rule once both sit at 15).
module round_controller
    import tron_pkg::*;
#(
    parameter int unsigned WIN_SCORE    = DEF_WIN_SCORE,
    parameter int unsigned CLEAR_CYCLES = DEF_CLEAR_CYCLES,
    parameter int unsigned HOLD_CYCLES  = DEF_HOLD_CYCLES,
    parameter int unsigned CNT_W        = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       p1_crash,
    input  logic       p2_crash,
    output logic       game_run,
    output logic       board_clear,
    output logic       p1_point,
    output logic       p2_point,
    output logic       score_clear,
    output logic [3:0] p1_score,
    output logic [3:0] p2_score,
    output logic       match_over,
    output logic [1:0] winner
);

    localparam logic [3:0]       WIN_THR   = 4'(WIN_SCORE);
    localparam logic [CNT_W-1:0] CLEAR_LIM = CNT_W'(CLEAR_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_LIM  = CNT_W'(HOLD_CYCLES);

    logic [2:0] state_q, state_d;
    // pend_q[0]: player 1 earns the point, pend_q[1]: player 2 earns it
    logic [1:0] pend_q, pend_d;
    logic [3:0] p1_q, p1_d, p2_q, p2_d;
    logic [1:0] win_q, win_d;
    logic       sclr_q, sclr_d;

    logic [3:0] p1_new, p2_new;
    logic       p1_wins, p2_wins;

    logic             tmr_clr, tmr_en, tmr_done;
    logic [CNT_W-1:0] tmr_limit;

    // Post-increment scores and match-win decision for the round being closed
    always_comb begin
        p1_new = pend_q[0] ? sat_inc(p1_q) : p1_q;
        p2_new = pend_q[1] ? sat_inc(p2_q) : p2_q;
`ifdef ROUND_CTRL_WIN_BY_TWO_EN
        // Both stuck at 15 means no lead can form; next decisive round settles it
        p1_wins = pend_q[0] && (((p1_q == 4'hF) && (p2_q == 4'hF)) ||
                  ((p1_new >= WIN_THR) && ({1'b0, p1_new} >= {1'b0, p2_new} + 5'd2)));
        p2_wins = pend_q[1] && (((p1_q == 4'hF) && (p2_q == 4'hF)) ||
                  ((p2_new >= WIN_THR) && ({1'b0, p2_new} >= {1'b0, p1_new} + 5'd2)));
`else
        p1_wins = pend_q[0] && (p1_new >= WIN_THR);
        p2_wins = pend_q[1] && (p2_new >= WIN_THR);
`endif
    end

    // Next-state logic for the match sequencer
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        p1_d    = p1_q;
        p2_d    = p2_q;
        win_d   = win_q;
        sclr_d  = 1'b0;
        case (state_q)
            IDLE, MATCH_OVER: begin
                if (start) begin
                    state_d = CLEAR;
                    sclr_d  = 1'b1;
                    p1_d    = 4'd0;
                    p2_d    = 4'd0;
                    win_d   = WIN_NONE;
                end
            end
            CLEAR: begin
                if (tmr_done) begin
                    state_d = PLAY;
                end
            end
            PLAY: begin
                if (p1_crash || p2_crash) begin
                    state_d = ROUND_END;
                    // A lone crash awards the opponent; a double crash is a draw
                    pend_d  = {p1_crash & ~p2_crash, p2_crash & ~p1_crash};
                end
            end
            ROUND_END: begin
                p1_d   = p1_new;
                p2_d   = p2_new;
                pend_d = 2'b00;
                if (p1_wins) begin
                    state_d = MATCH_OVER;
                    win_d   = WIN_P1;
                end else if (p2_wins) begin
                    state_d = MATCH_OVER;
                    win_d   = WIN_P2;
                end else begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (tmr_done) begin
                    state_d = CLEAR;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and shadow-score registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pend_q  <= 2'b00;
            p1_q    <= 4'd0;
            p2_q    <= 4'd0;
            win_q   <= WIN_NONE;
            sclr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            p1_q    <= p1_d;
            p2_q    <= p2_d;
            win_q   <= win_d;
            sclr_q  <= sclr_d;
        end
    end

    // Timer restarts on every state change and only runs in timed phases
    always_comb begin
        tmr_clr   = (state_d != state_q);
        tmr_en    = (state_q == CLEAR) || (state_q == HOLD);
        tmr_limit = (state_q == CLEAR) ? CLEAR_LIM : HOLD_LIM;
    end

    phase_timer #(
        .CNT_W (CNT_W)
    ) u_phase_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (tmr_clr),
        .en    (tmr_en),
        .limit (tmr_limit),
        .done  (tmr_done)
    );

    // Outputs decoded from registered state
    always_comb begin
        game_run    = (state_q == PLAY);
        board_clear = (state_q == CLEAR);
        p1_point    = (state_q == ROUND_END) && pend_q[0];
        p2_point    = (state_q == ROUND_END) && pend_q[1];
        score_clear = sclr_q;
        p1_score    = p1_q;
        p2_score    = p2_q;
        match_over  = (state_q == MATCH_OVER);
        winner      = win_q;
    end

endmodule

// File: tb/tb_round_controller.sv
// Scoreboard bench for round_controller (WIN_SCORE=3, CLEAR=3, HOLD=4).
// Honours ROUND_CTRL_WIN_BY_TWO_EN in its reference model.
module tb_round_controller;

    localparam int WIN = 3;
    localparam int EV_SCLR = 0;
    localparam int EV_P1 = 1;
    localparam int EV_P2 = 2;
    localparam int EV_MO = 3;

    typedef struct packed {
        logic [1:0] kind;
        logic [3:0] s1;
        logic [3:0] s2;
        logic [1:0] win;
    } ev_t;

    logic clk = 1'b0;
    logic reset, start, p1_crash, p2_crash;
    logic game_run, board_clear, p1_point, p2_point, score_clear, match_over;
    logic [3:0] p1_score, p2_score;
    logic [1:0] winner;

    int checks = 0;
    int errors = 0;
    ev_t sb[$];
    int m_p1 = 0;
    int m_p2 = 0;
    logic m_over = 1'b0;

    round_controller #(
        .WIN_SCORE    (3),
        .CLEAR_CYCLES (3),
        .HOLD_CYCLES  (4),
        .CNT_W        (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .p1_crash    (p1_crash),
        .p2_crash    (p2_crash),
        .game_run    (game_run),
        .board_clear (board_clear),
        .p1_point    (p1_point),
        .p2_point    (p2_point),
        .score_clear (score_clear),
        .p1_score    (p1_score),
        .p2_score    (p2_score),
        .match_over  (match_over),
        .winner      (winner)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_ev(input int kind, input int w);
        ev_t e;
        e.kind = 2'(kind);
        e.s1   = 4'(m_p1);
        e.s2   = 4'(m_p2);
        e.win  = 2'(w);
        sb.push_back(e);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a strobe or match end
    task automatic expect_ev(input int kind);
        ev_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind %0d expected none", kind);
        end else begin
            e = sb.pop_front();
            if (e.kind != 2'(kind)) begin
                errors++;
                $display("FAIL event_kind: got %0d expected %0d", kind, e.kind);
            end else if (kind == EV_MO &&
                         {winner, p1_score, p2_score} !== {e.win, e.s1, e.s2}) begin
                errors++;
                $display("FAIL match_result: got win %b %0d:%0d expected win %b %0d:%0d",
                         winner, p1_score, p2_score, e.win, e.s1, e.s2);
            end
        end
    endtask

    initial begin
        logic prev_strobe = 1'b0;
        logic prev_mo = 1'b0;
        logic [2:0] s;
        forever begin
            @(negedge clk);
            s = {score_clear, p2_point, p1_point};
            if (s != 3'b000) begin
                checks++;
                if (!$onehot(s) || prev_strobe) begin
                    errors++;
                    $display("FAIL strobe_excl: got %b prev %b expected one-hot, isolated",
                             s, prev_strobe);
                end
                if (score_clear) expect_ev(EV_SCLR);
                if (p1_point) expect_ev(EV_P1);
                if (p2_point) expect_ev(EV_P2);
            end
            prev_strobe = |s;
            if (match_over && !prev_mo) expect_ev(EV_MO);
            prev_mo = match_over;
        end
    end

    task automatic wait_clear();
        int cnt = 0;
        while (board_clear && cnt < 20) begin
            cnt++;
            tick();
        end
        check("clear_len", cnt, 3);
        check("run_after_clear", game_run, 1);
    endtask

    task automatic do_start();
        push_ev(EV_SCLR, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        m_p1 = 0;
        m_p2 = 0;
        m_over = 1'b0;
        check("clear_entry", board_clear, 1);
        check("scores_zeroed", {p1_score, p2_score}, 0);
        check("winner_zeroed", winner, 0);
        wait_clear();
    endtask

    // {c1, c2} crash pattern applied after two PLAY cycles
    task automatic play_round(input logic c1, input logic c2);
        logic p1pt, p2pt;
        int o1, o2;
        int w = 0;
        int cnt = 0;
        check("run_play", game_run, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        p1_crash = c1;
        p2_crash = c2;
        p1pt = c2 & ~c1;
        p2pt = c1 & ~c2;
        o1 = m_p1;
        o2 = m_p2;
        if (p1pt) begin
            push_ev(EV_P1, 0);
            if (m_p1 < 15) m_p1++;
        end
        if (p2pt) begin
            push_ev(EV_P2, 0);
            if (m_p2 < 15) m_p2++;
        end
`ifdef ROUND_CTRL_WIN_BY_TWO_EN
        if (p1pt && ((o1 == 15 && o2 == 15) || (m_p1 >= WIN && m_p1 >= m_p2 + 2))) w = 1;
        if (p2pt && ((o1 == 15 && o2 == 15) || (m_p2 >= WIN && m_p2 >= m_p1 + 2))) w = 2;
`else
        if (p1pt && m_p1 >= WIN) w = 1;
        if (p2pt && m_p2 >= WIN) w = 2;
`endif
        if (w != 0) begin
            m_over = 1'b1;
            push_ev(EV_MO, w);
        end
        tick();
        p1_crash = 1'b0;
        p2_crash = 1'b0;
        check("run_drop", game_run, 0);
        check("point_latency", {p2_point, p1_point}, {p2pt, p1pt});
        tick();
        check("p1_score", p1_score, m_p1);
        check("p2_score", p2_score, m_p2);
        check("match_over", match_over, m_over);
        if (!m_over) begin
            p1_crash = 1'b1;
            while (!board_clear && !match_over && cnt < 20) begin
                cnt++;
                tick();
            end
            p1_crash = 1'b0;
            check("hold_len", cnt, 4);
            wait_clear();
        end
    endtask

    initial begin
        logic [1:0] rounds [7];
        rounds = '{2'b01, 2'b11, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01};
        reset = 1'b1;
        start = 1'b0;
        p1_crash = 1'b0;
        p2_crash = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check("reset_outputs", {game_run, board_clear, p1_point, p2_point, score_clear,
              match_over, winner, p1_score, p2_score}, 0);
        tick();
        check("idle_quiet", {game_run, board_clear}, 0);

        do_start();
        for (int i = 0; i < 7; i++) begin
            if (!m_over) play_round(rounds[i][1], rounds[i][0]);
        end
        check("match_reached", match_over, 1);

        // Crashes ignored and winner held in MATCH_OVER
        p1_crash = 1'b1;
        tick();
        tick();
        tick();
        p1_crash = 1'b0;
        check("mo_hold", match_over, 1);
        check("winner_hold", winner, 1);

        do_start();
        tick();
        tick();
        reset = 1'b1;
        p1_crash = 1'b1;
        tick();
        reset = 1'b0;
        p1_crash = 1'b0;
        check("reset_mid_play", {game_run, board_clear, p1_point, p2_point, score_clear,
              match_over, winner, p1_score, p2_score}, 0);
        tick();
        tick();
        check("idle_after_reset", {game_run, board_clear, match_over}, 0);
        tick();
        check("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
